// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between NREQ masters, with a hold limit under contention.
// Latency: grant/sel/busy are registered, 1 cycle after req; mem_* mux outputs are combinational.
// Backpressure: a requester holds req until it is done; a long owner is preempted after MAX_HOLD cycles if others wait.
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   req/req_we              per-requester request and write enable
//   req_addr/req_wdata      per-requester address/data, requester i at [i*AW +: AW] / [i*DW +: DW]
//   gnt/sel/busy            registered one-hot grant, binary owner index, grant-active flag
//   mem_addr/mem_wdata      selected requester's address/data
//   mem_we                  selected write enable, suppressed when idle or the owner just dropped req
module mem_port_arbiter #(
    parameter int NREQ     = 4,
    parameter int AW       = 15,
    parameter int DW       = 16,
    parameter int MAX_HOLD = 8,
    localparam int SW      = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int HW      = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    input  logic [NREQ-1:0]    req_we,
    output logic [NREQ-1:0]    gnt,
    output logic [SW-1:0]      sel,
    output logic               busy,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    output logic               mem_we
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state, state_n;
    logic [SW-1:0]  ptr, ptr_n;
    logic [HW-1:0]  hold_cnt, hold_n;
    logic [NREQ-1:0] gnt_n;
    logic [SW-1:0]  sel_n;
    logic           busy_n;

    logic [NREQ-1:0] cand;
    logic [SW-1:0]   start;
    logic [SW-1:0]   nxt_own;
    logic [SW-1:0]   pos;
    logic [SW-1:0]   win;
    logic            found;

    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            sel      <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            gnt      <= gnt_n;
            sel      <= sel_n;
            busy     <= busy_n;
        end
    end

    // While granted, the owner is masked out and the search starts just after it,
    // so a release or preemption always hands the port to the next waiter in ring order.
    always_comb begin
        nxt_own = SW'((int'(sel) + 1) % NREQ);
        cand    = (state == GRANT) ? (req & ~gnt) : req;
        start   = (state == GRANT) ? nxt_own : ptr;
        found   = 1'b0;
        win     = '0;
        pos     = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = SW'((int'(start) + k) % NREQ);
            if (!found && cand[pos]) begin
                found = 1'b1;
                win   = pos;
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        gnt_n   = gnt;
        sel_n   = sel;
        busy_n  = busy;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = GRANT;
                    gnt_n   = NREQ'(1) << win;
                    sel_n   = win;
                    busy_n  = 1'b1;
                    hold_n  = '0;
                end else begin
                    gnt_n   = '0;
                    sel_n   = '0;
                    busy_n  = 1'b0;
                end
            end
            GRANT: begin
                if (!req[sel]) begin
                    ptr_n = nxt_own;
                    if (found) begin
                        gnt_n  = NREQ'(1) << win;
                        sel_n  = win;
                        hold_n = '0;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        sel_n   = '0;
                        busy_n  = 1'b0;
                        hold_n  = '0;
                    end
                end else if (hold_cnt == HOLD_LAST && found) begin
                    // Owner still wants the port but has used its share; it re-competes later.
                    ptr_n  = nxt_own;
                    gnt_n  = NREQ'(1) << win;
                    sel_n  = win;
                    hold_n = '0;
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_n = hold_cnt + HW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign mem_addr  = req_addr[sel*AW +: AW];
    assign mem_wdata = req_wdata[sel*DW +: DW];
    assign mem_we    = busy & req_we[sel] & req[sel];

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int NREQ     = 4;
    localparam int AW       = 15;
    localparam int DW       = 16;
    localparam int MAX_HOLD = 8;
    localparam int BOUND    = (NREQ - 1) * MAX_HOLD + 1;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic [NREQ-1:0]    req_we = '0;
    logic [NREQ-1:0]    gnt;
    logic [1:0]         sel;
    logic               busy;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic               mem_we;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_we(req_we), .gnt(gnt), .sel(sel), .busy(busy), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we)
    );

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic [1:0]      sel;
        logic            busy;
        logic            we;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   wdata;
        int              tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   row = 0;
    bit   rnd_phase = 1'b0;
    int   wcnt[NREQ];
    int   wmax[NREQ];

    // reference model state for the random phase
    bit   m_busy;
    int   m_own, m_ptr, m_hold;

    task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=0x%0h required=0x%0h", nm, tag, act, exp);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [NREQ-1:0] g);
        for (int i = 0; i < NREQ; i++)
            if (g[i]) return 2'(i);
        return 2'd0;
    endfunction

    // Apply one cycle of inputs and queue what the DUT must show during that cycle:
    // eg is the grant resulting from the previous cycle's inputs.
    task automatic drive(input logic rst, input logic [NREQ-1:0] r, input logic [NREQ-1:0] w,
                         input logic [NREQ-1:0] eg);
        exp_t e;
        logic [1:0] s;
        @(posedge clk);
        #1;
        reset  = rst;
        req    = r;
        req_we = w;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]  = AW'($urandom);
            req_wdata[i*DW +: DW] = DW'($urandom);
        end
        s       = idx_of(eg);
        e.gnt   = eg;
        e.sel   = s;
        e.busy  = |eg;
        e.we    = (|eg) & w[s] & r[s];
        e.addr  = req_addr[s*AW +: AW];
        e.wdata = req_wdata[s*DW +: DW];
        e.tag   = row;
        row++;
        sb.push_back(e);
    endtask

    function automatic int pick(input int base, input logic [NREQ-1:0] m);
        int best, bestd, d;
        best  = -1;
        bestd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            d = (i - base + NREQ) % NREQ;
            if (m[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    task automatic model_step(input logic [NREQ-1:0] r);
        logic [NREQ-1:0] others;
        int nxt, w;
        if (!m_busy) begin
            w = pick(m_ptr, r);
            if (w >= 0) begin
                m_busy = 1'b1; m_own = w; m_hold = 0;
            end
        end else begin
            others = r;
            others[m_own] = 1'b0;
            nxt = (m_own + 1) % NREQ;
            if (!r[m_own]) begin
                m_ptr = nxt;
                w = pick(nxt, others);
                if (w >= 0) begin
                    m_own = w; m_hold = 0;
                end else begin
                    m_busy = 1'b0; m_own = 0; m_hold = 0;
                end
            end else if (m_hold == MAX_HOLD - 1 && others != '0) begin
                m_ptr  = nxt;
                m_own  = pick(nxt, others);
                m_hold = 0;
            end else if (m_hold < MAX_HOLD - 1) begin
                m_hold++;
            end
        end
    endtask

    // monitor: compare every cycle the DUT presents against the oldest expectation
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("gnt",       mon_e.tag, 32'(gnt),       32'(mon_e.gnt));
            chk("sel",       mon_e.tag, 32'(sel),       32'(mon_e.sel));
            chk("busy",      mon_e.tag, 32'(busy),      32'(mon_e.busy));
            chk("mem_we",    mon_e.tag, 32'(mem_we),    32'(mon_e.we));
            chk("mem_addr",  mon_e.tag, 32'(mem_addr),  32'(mon_e.addr));
            chk("mem_wdata", mon_e.tag, 32'(mem_wdata), 32'(mon_e.wdata));
        end
        for (int i = 0; i < NREQ; i++) begin
            if (rnd_phase && req[i] && !gnt[i]) begin
                wcnt[i]++;
                if (wcnt[i] > wmax[i]) wmax[i] = wcnt[i];
            end else begin
                wcnt[i] = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog row=%0d actual=timeout required=finish", row);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] r_cur, w_cur, eg;
        for (int i = 0; i < NREQ; i++) begin
            wcnt[i] = 0;
            wmax[i] = 0;
        end

        // single requester, 1-cycle grant latency, release to idle
        drive(1, 4'b0000, 4'b0000, 4'b0000);
        drive(0, 4'b0001, 4'b0001, 4'b0000);
        drive(0, 4'b0001, 4'b0001, 4'b0001);
        drive(0, 4'b0000, 4'b0001, 4'b0001);
        drive(0, 4'b0000, 4'b0000, 4'b0000);

        // simultaneous from reset, gapless handover, write masked on release
        drive(1, 4'b0000, 4'b0000, 4'b0000);
        drive(0, 4'b0101, 4'b0101, 4'b0000);
        drive(0, 4'b0101, 4'b0101, 4'b0001);
        drive(0, 4'b0100, 4'b0101, 4'b0001);
        drive(0, 4'b0100, 4'b0101, 4'b0100);
        drive(0, 4'b0000, 4'b0101, 4'b0100);
        drive(0, 4'b0000, 4'b0000, 4'b0000);

        // ptr=3 now: search wraps to 0; constant contention alternates every 8 cycles
        drive(0, 4'b0011, 4'b0011, 4'b0000);
        for (int blk = 0; blk < 3; blk++)
            repeat (8) drive(0, 4'b0011, 4'b0011, (blk % 2 == 1) ? 4'b0010 : 4'b0001);
        drive(0, 4'b0000, 4'b0000, 4'b0010);
        drive(0, 4'b0000, 4'b0000, 4'b0000);

        // lone requester is never preempted
        drive(0, 4'b1000, 4'b1000, 4'b0000);
        repeat (20) drive(0, 4'b1000, 4'b1000, 4'b1000);
        drive(0, 4'b0000, 4'b0000, 4'b1000);
        drive(0, 4'b0000, 4'b0000, 4'b0000);

        // move ptr to 2, then reset mid-grant: outputs clear and restart picks index 0
        drive(0, 4'b0110, 4'b0100, 4'b0000);
        drive(0, 4'b0110, 4'b0100, 4'b0010);
        drive(0, 4'b0100, 4'b0100, 4'b0010);
        drive(0, 4'b0100, 4'b0100, 4'b0100);
        drive(1, 4'b0101, 4'b0100, 4'b0100);
        drive(0, 4'b0101, 4'b0100, 4'b0000);
        drive(0, 4'b0101, 4'b0100, 4'b0001);
        drive(0, 4'b0000, 4'b0000, 4'b0001);
        drive(0, 4'b0000, 4'b0000, 4'b0000);

        // random traffic against the reference model
        drive(1, 4'b0000, 4'b0000, 4'b0000);
        m_busy = 1'b0; m_own = 0; m_ptr = 0; m_hold = 0;
        r_cur = '0;
        rnd_phase = 1'b1;
        repeat (3000) begin
            for (int i = 0; i < NREQ; i++) begin
                if (r_cur[i]) begin
                    if (m_busy && m_own == i && $urandom_range(11) == 0) r_cur[i] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    r_cur[i] = 1'b1;
                end
            end
            w_cur = NREQ'($urandom);
            eg    = m_busy ? NREQ'(1 << m_own) : '0;
            drive(0, r_cur, w_cur, eg);
            model_step(r_cur);
        end
        @(posedge clk);
        #1;
        rnd_phase = 1'b0;
        repeat (3) @(negedge clk);

        chk("drain", row, 32'(sb.size()), 32'd0);
        for (int i = 0; i < NREQ; i++) begin
            checks++;
            if (wmax[i] > BOUND) begin
                failures++;
                $display("FAIL wait_bound req=%0d actual=%0d required<=%0d", i, wmax[i], BOUND);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
